// File: rtl/rr_port_allocator.sv
// rr_port_allocator: round-robin output-port allocator for a 5-port router.
// Grants are combinational from req_i and registered state; downstream
// buffer space is tracked with a credit counter that starts at DEPTH.
// Optional wormhole packet lock is enabled by defining RR_ALLOC_PKT_LOCK_EN;
// without it every flit is arbitrated independently and tail_i is ignored.
module rr_port_allocator #(
  parameter int DEPTH = 4,
  parameter int NREQ  = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NREQ-1:0]              req_i,
  input  logic [NREQ-1:0]              tail_i,
  input  logic                         credit_i,
  output logic [NREQ-1:0]              grant_o,
  output logic [2:0]                   sel_o,
  output logic                         send_en_o,
  output logic [$clog2(DEPTH+1)-1:0]   credit_cnt_o,
  output logic                         locked_o,
  output logic                         err_o
);

  localparam int             CW      = $clog2(DEPTH+1);
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0]  ZERO_C  = {CW{1'b0}};
  localparam logic [CW-1:0]  ONE_C   = {{(CW-1){1'b0}}, 1'b1};

  // Index of the requester after k, wrapping 4 -> 0.
  function automatic logic [2:0] next_idx(input logic [2:0] k);
    if (k >= 3'd4) begin
      next_idx = 3'd0;
    end else begin
      next_idx = k + 3'd1;
    end
  endfunction

`ifdef RR_ALLOC_PKT_LOCK_EN
  typedef enum logic {ST_IDLE = 1'b0, ST_LOCK = 1'b1} state_t;
  state_t      state_q, state_d;
  logic [2:0]  owner_q, owner_d;
`else
  logic        unused_tail_s;
  assign unused_tail_s = ^tail_i;
`endif

  logic [2:0]    ptr_q, ptr_d;
  logic [CW-1:0] credit_q, credit_d;
  logic          err_q, err_d;

  logic          scan_hit_s;
  logic [2:0]    scan_win_s;
  logic [3:0]    scan_sum_s;
  logic          hit_s;
  logic [2:0]    win_s;
  logic [NREQ-1:0] grant_s;

  // Round-robin scan: first asserted request at or after ptr, with wrap.
  always_comb begin
    scan_hit_s = 1'b0;
    scan_win_s = 3'b111;
    scan_sum_s = 4'd0;
    for (int i = 0; i < NREQ; i++) begin
      scan_sum_s = {1'b0, ptr_q} + 4'(i);
      if (scan_sum_s >= 4'd5) begin
        scan_sum_s = scan_sum_s - 4'd5;
      end else begin
        scan_sum_s = scan_sum_s;
      end
      if (!scan_hit_s && req_i[scan_sum_s[2:0]]) begin
        scan_hit_s = 1'b1;
        scan_win_s = scan_sum_s[2:0];
      end else begin
        scan_hit_s = scan_hit_s;
      end
    end
  end

  // Winner selection: no grant in reset or without credit; owner only when locked.
  always_comb begin
    hit_s   = 1'b0;
    win_s   = 3'b111;
    grant_s = {NREQ{1'b0}};
    if (rst && (credit_q != ZERO_C)) begin
`ifdef RR_ALLOC_PKT_LOCK_EN
      if (state_q == ST_LOCK) begin
        if (req_i[owner_q]) begin
          hit_s = 1'b1;
          win_s = owner_q;
        end else begin
          hit_s = 1'b0;
        end
      end else begin
        hit_s = scan_hit_s;
        win_s = scan_win_s;
      end
`else
      hit_s = scan_hit_s;
      win_s = scan_win_s;
`endif
    end else begin
      hit_s = 1'b0;
    end
    if (hit_s) begin
      grant_s[win_s] = 1'b1;
    end else begin
      grant_s = {NREQ{1'b0}};
    end
  end

  // Next-state: credit accounting, sticky overflow, pointer and lock FSM.
  always_comb begin
    ptr_d    = ptr_q;
    credit_d = credit_q;
    err_d    = err_q;
`ifdef RR_ALLOC_PKT_LOCK_EN
    state_d  = state_q;
    owner_d  = owner_q;
`endif
    case ({hit_s, credit_i})
      2'b10: credit_d = credit_q - ONE_C;
      2'b01: begin
        if (credit_q == DEPTH_C) begin
          err_d = 1'b1;
        end else begin
          credit_d = credit_q + ONE_C;
        end
      end
      default: credit_d = credit_q;
    endcase

    if (hit_s) begin
`ifdef RR_ALLOC_PKT_LOCK_EN
      if (state_q == ST_IDLE) begin
        if (tail_i[win_s]) begin
          ptr_d = next_idx(win_s);
        end else begin
          state_d = ST_LOCK;
          owner_d = win_s;
        end
      end else begin
        if (tail_i[owner_q]) begin
          state_d = ST_IDLE;
          ptr_d   = next_idx(owner_q);
        end else begin
          state_d = ST_LOCK;
        end
      end
`else
      ptr_d = next_idx(win_s);
`endif
    end else begin
      ptr_d = ptr_q;
    end
  end

  // State registers; reset abandons any lock and restarts arbitration at 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q    <= 3'd0;
      credit_q <= DEPTH_C;
      err_q    <= 1'b0;
`ifdef RR_ALLOC_PKT_LOCK_EN
      state_q  <= ST_IDLE;
      owner_q  <= 3'd0;
`endif
    end else begin
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
      err_q    <= err_d;
`ifdef RR_ALLOC_PKT_LOCK_EN
      state_q  <= state_d;
      owner_q  <= owner_d;
`endif
    end
  end

  assign grant_o      = grant_s;
  assign sel_o        = win_s;
  assign send_en_o    = |grant_s;
  assign credit_cnt_o = credit_q;
  assign err_o        = err_q;
`ifdef RR_ALLOC_PKT_LOCK_EN
  assign locked_o     = (state_q == ST_LOCK);
`else
  assign locked_o     = 1'b0;
`endif

endmodule

// File: tb/tb_rr_port_allocator.sv
// Testbench for rr_port_allocator: directed scenarios plus randomized traffic
// checked against a queue-free arithmetic reference model of the allocator.
module tb_rr_port_allocator;

  localparam int DEPTH = 4;

  logic       clk;
  logic       rst;
  logic [4:0] req;
  logic [4:0] tail;
  logic       cred;
  logic [4:0] grant_o;
  logic [2:0] sel_o;
  logic       send_en_o;
  logic [2:0] credit_cnt_o;
  logic       locked_o;
  logic       err_o;

  int total = 0;
  int bad   = 0;

  // reference model state
  int m_credit;
  int m_ptr;
  int m_owner;
  bit m_lock;
  bit m_err;

  rr_port_allocator #(.DEPTH(DEPTH), .NREQ(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_i        (req),
    .tail_i       (tail),
    .credit_i     (cred),
    .grant_o      (grant_o),
    .sel_o        (sel_o),
    .send_en_o    (send_en_o),
    .credit_cnt_o (credit_cnt_o),
    .locked_o     (locked_o),
    .err_o        (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int exp_win();
    if (!rst || m_credit == 0) return -1;
`ifdef RR_ALLOC_PKT_LOCK_EN
    if (m_lock) return req[m_owner] ? m_owner : -1;
`endif
    for (int i = 0; i < 5; i++) begin
      int k;
      k = (m_ptr + i) % 5;
      if (req[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic [4:0] exp_gnt(input int w);
    logic [4:0] one;
    one = 5'b00001;
    return (w < 0) ? 5'b00000 : (one << w);
  endfunction

  function automatic logic [2:0] exp_sel(input int w);
    return (w < 0) ? 3'b111 : 3'(w);
  endfunction

  task automatic model_reset();
    m_credit = DEPTH; m_ptr = 0; m_owner = 0; m_lock = 0; m_err = 0;
  endtask

  task automatic drive(input logic [4:0] r, input logic [4:0] t, input logic c);
    req = r; tail = t; cred = c;
    #1;
  endtask

  // apply the current cycle to the model, then move to the next falling edge
  task automatic advance();
    int w;
    w = exp_win();
    if (w >= 0 && !cred) m_credit = m_credit - 1;
    else if (w < 0 && cred) begin
      if (m_credit == DEPTH) m_err = 1;
      else m_credit = m_credit + 1;
    end
    if (w >= 0) begin
`ifdef RR_ALLOC_PKT_LOCK_EN
      if (!m_lock) begin
        if (tail[w]) m_ptr = (w + 1) % 5;
        else begin m_lock = 1; m_owner = w; end
      end else if (tail[m_owner]) begin
        m_lock = 0; m_ptr = (m_owner + 1) % 5;
      end
`else
      m_ptr = (w + 1) % 5;
`endif
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0; req = 5'b0; tail = 5'b0; cred = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; req = 5'b11111; tail = 5'b11111; cred = 1'b1;
    model_reset();
    #1;
    total++;
    if ({grant_o, sel_o, send_en_o, locked_o, err_o} !== {5'b0, 3'b111, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_outputs: got grant=%b sel=%0d en=%b lock=%b err=%b, want 0/7/0/0/0",
               grant_o, sel_o, send_en_o, locked_o, err_o);
    end
    total++;
    if (credit_cnt_o !== 3'd4) begin
      bad++;
      $display("FAIL reset_credit: got %0d want 4", credit_cnt_o);
    end
    @(negedge clk);
    rst = 1'b1; req = 5'b0; tail = 5'b0; cred = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_rr_basic();
    logic [4:0] eg [3];
    logic [2:0] es [3];
    eg[0] = 5'b00001; eg[1] = 5'b00100; eg[2] = 5'b10000;
    es[0] = 3'd0; es[1] = 3'd2; es[2] = 3'd4;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(5'b10101, 5'b11111, 1'b1);
      total++;
      if (grant_o !== eg[i] || sel_o !== es[i] || send_en_o !== 1'b1) begin
        bad++;
        $display("FAIL rr_basic[%0d]: got grant=%b sel=%0d en=%b, want %b/%0d/1",
                 i, grant_o, sel_o, send_en_o, eg[i], es[i]);
      end
      advance();
    end
    total++;
    if (credit_cnt_o !== 3'd4) begin
      bad++;
      $display("FAIL rr_basic_credit: got %0d want 4", credit_cnt_o);
    end
  endtask

  task automatic test_credit_exhaust();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(5'b00010, 5'b11111, 1'b0);
      total++;
      if (grant_o !== 5'b00010 || sel_o !== 3'd1 || credit_cnt_o !== 3'(4 - i)) begin
        bad++;
        $display("FAIL exhaust_grant[%0d]: got grant=%b sel=%0d cnt=%0d, want 00010/1/%0d",
                 i, grant_o, sel_o, credit_cnt_o, 4 - i);
      end
      advance();
    end
    drive(5'b00010, 5'b11111, 1'b0);
    total++;
    if (grant_o !== 5'b0 || sel_o !== 3'b111 || send_en_o !== 1'b0 || credit_cnt_o !== 3'd0) begin
      bad++;
      $display("FAIL exhaust_empty: got grant=%b sel=%0d en=%b cnt=%0d, want 0/7/0/0",
               grant_o, sel_o, send_en_o, credit_cnt_o);
    end
    advance();
    drive(5'b00010, 5'b11111, 1'b1);
    advance();
    drive(5'b00010, 5'b11111, 1'b0);
    total++;
    if (grant_o !== 5'b00010 || credit_cnt_o !== 3'd1) begin
      bad++;
      $display("FAIL exhaust_one_more: got grant=%b cnt=%0d, want 00010/1", grant_o, credit_cnt_o);
    end
    advance();
    drive(5'b00010, 5'b11111, 1'b0);
    total++;
    if (grant_o !== 5'b0 || credit_cnt_o !== 3'd0) begin
      bad++;
      $display("FAIL exhaust_only_one: got grant=%b cnt=%0d, want 0/0", grant_o, credit_cnt_o);
    end
    advance();
  endtask

  // continues from an empty credit count left by test_credit_exhaust
  task automatic test_credit_same_cycle();
    drive(5'b0, 5'b0, 1'b1); advance();
    drive(5'b0, 5'b0, 1'b1); advance();
    drive(5'b00001, 5'b11111, 1'b1);
    total++;
    if (grant_o !== 5'b00001 || credit_cnt_o !== 3'd2) begin
      bad++;
      $display("FAIL same_cycle_grant: got grant=%b cnt=%0d, want 00001/2", grant_o, credit_cnt_o);
    end
    advance();
    drive(5'b0, 5'b0, 1'b0);
    total++;
    if (credit_cnt_o !== 3'd2 || err_o !== 1'b0) begin
      bad++;
      $display("FAIL same_cycle_hold: got cnt=%0d err=%b, want 2/0", credit_cnt_o, err_o);
    end
    advance();
    drive(5'b0, 5'b0, 1'b1); advance();
    drive(5'b0, 5'b0, 1'b1); advance();
    drive(5'b0, 5'b0, 1'b1);
    total++;
    if (credit_cnt_o !== 3'd4 || err_o !== 1'b0) begin
      bad++;
      $display("FAIL overflow_pre: got cnt=%0d err=%b, want 4/0", credit_cnt_o, err_o);
    end
    advance();
    drive(5'b0, 5'b0, 1'b0);
    total++;
    if (credit_cnt_o !== 3'd4 || err_o !== 1'b1) begin
      bad++;
      $display("FAIL overflow_sat: got cnt=%0d err=%b, want 4/1", credit_cnt_o, err_o);
    end
    advance();
    drive(5'b0, 5'b0, 1'b0);
    total++;
    if (err_o !== 1'b1) begin
      bad++;
      $display("FAIL overflow_sticky: got err=%b want 1", err_o);
    end
    advance();
  endtask

`ifdef RR_ALLOC_PKT_LOCK_EN
  task automatic test_packet_lock();
    logic [4:0] rq [4];
    logic [4:0] tl [4];
    logic [4:0] eg [4];
    logic       el [4];
    rq[0] = 5'b10100; tl[0] = 5'b00000; eg[0] = 5'b00100; el[0] = 1'b0;
    rq[1] = 5'b10100; tl[1] = 5'b00000; eg[1] = 5'b00100; el[1] = 1'b1;
    rq[2] = 5'b10100; tl[2] = 5'b00100; eg[2] = 5'b00100; el[2] = 1'b1;
    rq[3] = 5'b10101; tl[3] = 5'b10001; eg[3] = 5'b10000; el[3] = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(rq[i], tl[i], 1'b1);
      total++;
      if (grant_o !== eg[i] || locked_o !== el[i]) begin
        bad++;
        $display("FAIL packet_lock[%0d]: got grant=%b locked=%b, want %b/%b",
                 i, grant_o, locked_o, eg[i], el[i]);
      end
      advance();
    end
  endtask
`else
  task automatic test_alternate();
    logic [4:0] eg [4];
    eg[0] = 5'b00100; eg[1] = 5'b10000; eg[2] = 5'b00100; eg[3] = 5'b10000;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(5'b10100, 5'b00000, 1'b1);
      total++;
      if (grant_o !== eg[i] || locked_o !== 1'b0) begin
        bad++;
        $display("FAIL alternate[%0d]: got grant=%b locked=%b, want %b/0",
                 i, grant_o, locked_o, eg[i]);
      end
      advance();
    end
  endtask
`endif

  task automatic test_reset_mid();
    do_reset();
    drive(5'b01000, 5'b00000, 1'b0); advance();
    drive(5'b01000, 5'b00000, 1'b0);
    total++;
    if (grant_o !== 5'b01000 || credit_cnt_o !== 3'd3) begin
      bad++;
      $display("FAIL mid_pre: got grant=%b cnt=%0d, want 01000/3", grant_o, credit_cnt_o);
    end
`ifdef RR_ALLOC_PKT_LOCK_EN
    total++;
    if (locked_o !== 1'b1) begin
      bad++;
      $display("FAIL mid_locked: got %b want 1", locked_o);
    end
`endif
    advance();
    rst = 1'b0;
    model_reset();
    #1;
    total++;
    if ({grant_o, sel_o, send_en_o, locked_o} !== {5'b0, 3'b111, 1'b0, 1'b0} || credit_cnt_o !== 3'd4) begin
      bad++;
      $display("FAIL mid_reset: got grant=%b sel=%0d en=%b lock=%b cnt=%0d, want 0/7/0/0/4",
               grant_o, sel_o, send_en_o, locked_o, credit_cnt_o);
    end
    @(negedge clk);
    rst = 1'b1;
    drive(5'b11111, 5'b11111, 1'b0);
    total++;
    if (grant_o !== 5'b00001 || sel_o !== 3'd0) begin
      bad++;
      $display("FAIL mid_restart: got grant=%b sel=%0d, want 00001/0", grant_o, sel_o);
    end
    advance();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      int w;
      drive(5'($urandom), 5'($urandom) | 5'($urandom), ($urandom_range(0, 2) == 0));
      w = exp_win();
      total++;
      if ({grant_o, sel_o, send_en_o, credit_cnt_o, locked_o, err_o} !==
          {exp_gnt(w), exp_sel(w), (w >= 0), 3'(m_credit), m_lock, m_err}) begin
        bad++;
        $display("FAIL random[%0d]: got grant=%b sel=%0d en=%b cnt=%0d lock=%b err=%b, want %b/%0d/%0d/%0d/%0d/%0d",
                 n, grant_o, sel_o, send_en_o, credit_cnt_o, locked_o, err_o,
                 exp_gnt(w), exp_sel(w), (w >= 0), m_credit, m_lock, m_err);
      end
      advance();
    end
  endtask

  initial begin
    rst = 1'b0; req = 5'b0; tail = 5'b0; cred = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_rr_basic();
    test_credit_exhaust();
    test_credit_same_cycle();
`ifdef RR_ALLOC_PKT_LOCK_EN
    test_packet_lock();
`else
    test_alternate();
`endif
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
